alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 2, the requester count; legal range 2-8.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-007 SHALL have port req_op0  input  NUM_REQ*DATA_WIDTH  per-requester operand 0, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_op1  input  NUM_REQ*DATA_WIDTH  per-requester operand 1, same packing.
REQ-009 SHALL have port req_sel  input  NUM_REQ*4  per-requester 4-bit ALU select code.
REQ-010 SHALL have port req_lock  input  NUM_REQ  per-requester lock request (used only under ALU_ARB_LOCK_EN).
REQ-011 SHALL have ports alu_input0, alu_input1  output  DATA_WIDTH each, and aluselect  output  4, driving the shared combinational ALU.
REQ-012 SHALL have port alu_out  input  DATA_WIDTH  shared ALU result, same cycle as its inputs.
REQ-013 SHALL have ports rsp_valid  output  1,  rsp_ready  input  1,  rsp_data  output  DATA_WIDTH,  rsp_id  output  $clog2(NUM_REQ)  (registered response and originating requester).

Function
REQ-014 SHALL accept an operation from requester i in a cycle iff req_valid[i] && req_ready[i] (accept cycle).
REQ-015 SHALL assert at most one req_ready bit per cycle, and only when can_issue = !rsp_valid || rsp_ready.
REQ-016 SHALL grant round-robin: search starts at (last_grant+1) mod NUM_REQ; first valid requester wins; last_grant updates to the winner on accept.
REQ-017 SHALL drive alu_input0/alu_input1/aluselect from the granted requester combinationally in the accept cycle, and all-zero when no grant.
REQ-018 SHALL register alu_out into rsp_data and the winner index into rsp_id on accept; rsp_valid rises the next cycle (latency 1).
REQ-019 SHALL hold rsp_valid/rsp_data/rsp_id stable while rsp_valid && !rsp_ready.
REQ-020 SHALL, with rsp_valid && rsp_ready and a new accept in the same cycle, replace the response with no bubble (throughput 1 op/cycle).
REQ-021 SHALL clear rsp_valid on rsp_valid && rsp_ready with no new accept.
REQ-022 SHALL forward select codes 12-15 unchanged; no error flagged.
REQ-023 SHALL give req_ready no combinational dependency on req_op0/req_op1/req_sel.
REQ-024 SHALL use two FSM states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY->FULL on accept. FULL->EMPTY on rsp_ready without accept. FULL->FULL on stall or on drain+accept.

Reset
REQ-025 SHALL, when rst_n=0 at a clk edge, set rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), lock state cleared.
REQ-026 SHALL force req_ready=0 while rst_n=0; a response pending at reset is discarded.

Configuration
REQ-027 SHALL compile requester locking in only when macro ALU_ARB_LOCK_EN is defined.
REQ-028 SHALL, with ALU_ARB_LOCK_EN, set lock_active/lock_owner when an accept has req_lock=1.
REQ-029 SHALL, with ALU_ARB_LOCK_EN and lock_active, grant only lock_owner, idling if the owner is not valid.
REQ-030 SHALL, with ALU_ARB_LOCK_EN, clear lock_active on an owner accept with req_lock=0.
REQ-031 SHALL, without ALU_ARB_LOCK_EN, ignore req_lock and contain no lock state.

Verification
REQ-032 Single op: req_valid=01, op0=5, op1=3, sel=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=2, rsp_id=0.
REQ-033 Contention: both valid continuously, req0 sel=0 (7+1), req1 sel=5 (0xF0&0x3C) -> grants alternate 0,1,0,1; responses 8, 0x30, 8, 0x30 back-to-back.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles after an accept -> req_ready=00, response stable; rsp_ready=1 -> drain and new accept in same cycle.
REQ-035 Signed compare: op0=0xFFFFFFFF, op1=1, sel=8 -> rsp_data=1; sel=9 -> rsp_data=0.
REQ-036 Mid-operation reset: rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0; first post-reset grant goes to requester 0.
REQ-037 With ALU_ARB_LOCK_EN: req1 issues 3 ops with lock=1,1,0 while req0 is valid -> req0 granted only after req1's third op.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external combinational ALU
// among NUM_REQ requesters and holds the result in a one-entry registered
// response stage (latency 1, throughput 1 op/cycle).
// Optional requester locking is compiled in when macro ALU_ARB_LOCK_EN is
// defined; the default build ignores req_lock and holds no lock state.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*4-1:0]          req_sel,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [DATA_WIDTH-1:0]         alu_input0,
  output logic [DATA_WIDTH-1:0]         alu_input1,
  output logic [3:0]                    aluselect,
  input  logic [DATA_WIDTH-1:0]         alu_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  // Wide enough to hold last_grant + k (k up to NUM_REQ) before wrapping.
  localparam int CW   = ID_W + 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ID_W-1:0]       r_rsp_id;
  logic [ID_W-1:0]       r_last_grant;

  logic                  w_lock_hold;
  logic [ID_W-1:0]       w_lock_owner;
  logic                  w_found;
  logic [ID_W-1:0]       w_grant_idx;
  logic [CW-1:0]         w_sum;
  logic [ID_W-1:0]       w_pos;
  logic                  w_can_issue;
  logic                  w_accept;

`ifdef ALU_ARB_LOCK_EN
  logic            r_lock_active;
  logic [ID_W-1:0] r_lock_owner;

  assign w_lock_hold  = r_lock_active;
  assign w_lock_owner = r_lock_owner;

  // Lock tracking: an accept with req_lock set claims the ALU for that
  // requester; the owner's next accept without req_lock releases it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= '0;
    end else if (w_accept && req_lock[w_grant_idx]) begin
      r_lock_active <= 1'b1;
      r_lock_owner  <= w_grant_idx;
    end else if (w_accept && r_lock_active && (w_grant_idx == r_lock_owner)) begin
      r_lock_active <= 1'b0;
    end else begin
      r_lock_active <= r_lock_active;
      r_lock_owner  <= r_lock_owner;
    end
  end
`else
  logic w_unused_lock;

  assign w_lock_hold   = 1'b0;
  assign w_lock_owner  = '0;
  assign w_unused_lock = ^req_lock;
`endif

  // Winner search: locked owner only, else round-robin from last_grant+1.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_pos       = '0;
    if (w_lock_hold) begin
      w_found     = req_valid[w_lock_owner];
      w_grant_idx = w_lock_owner;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_sum = CW'(r_last_grant) + CW'(k);
        w_pos = (w_sum >= CW'(NUM_REQ)) ? ID_W'(w_sum - CW'(NUM_REQ)) : ID_W'(w_sum);
        if (!w_found && req_valid[w_pos]) begin
          w_found     = 1'b1;
          w_grant_idx = w_pos;
        end else begin
          w_found     = w_found;
        end
      end
    end
  end

  // Issue is allowed only out of reset and when the response slot frees up;
  // req_ready therefore depends on valids and state, never on operand data.
  assign w_can_issue = (r_state == ST_EMPTY) || rsp_ready;
  assign w_accept    = rst_n && w_can_issue && w_found;

  // Grant and ALU drive: winner's operands in the accept cycle, zero otherwise.
  always_comb begin
    req_ready  = '0;
    alu_input0 = '0;
    alu_input1 = '0;
    aluselect  = 4'd0;
    if (w_accept) begin
      req_ready  = NUM_REQ'(1) << w_grant_idx;
      alu_input0 = req_op0[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      alu_input1 = req_op1[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      aluselect  = req_sel[w_grant_idx*4 +: 4];
    end else begin
      req_ready  = '0;
    end
  end

  // Response slot next state: fill on accept, drain on rsp_ready, else hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State, response payload and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rsp_data   <= alu_out;
        r_rsp_id     <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end else begin
        r_rsp_data   <= r_rsp_data;
        r_rsp_id     <= r_rsp_id;
        r_last_grant <= r_last_grant;
      end
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule
